// File: rtl/fx3_bus_reader_pkg.sv
// Shared definitions for the FX3 GPIF read-side model: bus width, default
// test-counter width and the capture state encoding.
package fx3_pkg;

  localparam int DATA_WIDTH          = 16;
  localparam int SAMPLE_BITS_DEFAULT = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    GAP   = 3'd4
  } state_e;

endpackage

// File: rtl/fx3_bus_reader_if.sv
// Reader <-> data generator bus: control strobes toward the generator and the
// 16-bit databus plus availability flag coming back.
interface fx3_bus_reader_if;
  import fx3_pkg::*;

  logic                  collectData;
  logic                  testMode;
  logic                  readData;
  logic                  dataAvailable;
  logic [DATA_WIDTH-1:0] dataIn;

  modport master (
    output collectData,
    output testMode,
    output readData,
    input  dataAvailable,
    input  dataIn
  );

  modport slave (
    input  collectData,
    input  testMode,
    input  readData,
    output dataAvailable,
    output dataIn
  );

endinterface

// File: rtl/fx3_pattern_checker.sv
// Test-counter continuity checker: the first valid word after a seed clear seeds
// the expected value, later words are compared and resync on a mismatch.
module fx3_pattern_checker
  import fx3_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_sample_valid,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_test_mode,
  input  logic                   i_seed_clear,
  output logic                   o_mismatch,
  output logic [SAMPLE_BITS-1:0] o_expected
);

  logic                   r_seeded;
  logic [SAMPLE_BITS-1:0] r_expected;
  logic [SAMPLE_BITS-1:0] w_sample;
  logic                   w_check;
  logic                   w_bad;

  assign w_sample   = i_data[SAMPLE_BITS-1:0];
  assign w_check    = i_sample_valid & i_test_mode;
  assign w_bad      = (i_data[DATA_WIDTH-1:SAMPLE_BITS] != '0) || (w_sample != r_expected);
  assign o_mismatch = w_check & r_seeded & w_bad;
  assign o_expected = r_expected;

  // Seed / advance / resync of the expected counter value (wraps naturally)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seeded   <= 1'b0;
      r_expected <= '0;
    end else if (i_seed_clear) begin
      r_seeded   <= 1'b0;
      r_expected <= '0;
    end else if (w_check) begin
      r_seeded <= 1'b1;
      if (r_seeded && !w_bad) begin
        r_expected <= r_expected + SAMPLE_BITS'(1);
      end else begin
        r_expected <= w_sample + SAMPLE_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/fx3_bus_reader.sv
// FX3 GPIF read-side capture engine: arms the generator, pulls fixed-length
// bursts, drains in-flight words and keeps word/burst/error statistics.
module fx3_bus_reader
  import fx3_pkg::*;
#(
  parameter int BURST_LEN    = 8192,
  parameter int READ_LATENCY = 2,
  parameter int GAP_CYCLES   = 4,
  parameter int SAMPLE_BITS  = SAMPLE_BITS_DEFAULT
) (
  input  logic                   inclk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   testModeReq,
  fx3_bus_reader_if.master       bus,
  output logic                   busy,
  output logic [31:0]            wordCount,
  output logic [15:0]            burstCount,
  output logic [15:0]            errorCount,
  output logic                   errorSeen
);

  state_e                  r_state;
  state_e                  w_next;
  logic [31:0]             r_cnt;
  logic                    r_collect, r_test, r_read, r_busy;
  logic                    w_collect, w_test, w_read, w_busy;
  logic [READ_LATENCY-1:0] r_vpipe;
  logic [31:0]             r_word_cnt;
  logic [15:0]             r_burst_cnt, r_err_cnt;
  logic                    r_err_seen;
  logic                    w_sample_valid, w_seed_clear, w_mismatch;
  logic                    w_burst_done, w_drain_done, w_gap_done;
  logic [SAMPLE_BITS-1:0]  w_expected_unused;

  assign w_burst_done   = (r_state == READ)  && (r_cnt == 32'(BURST_LEN - 1));
  assign w_drain_done   = (r_state == DRAIN) && (r_cnt == 32'(READ_LATENCY - 1));
  assign w_gap_done     = (r_state == GAP)   && (r_cnt == 32'(GAP_CYCLES - 1));
  assign w_seed_clear   = (r_state == IDLE)  && enable;
  assign w_sample_valid = r_vpipe[READ_LATENCY-1];

  // State register and per-state cycle counter
  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 32'd0 : r_cnt + 32'd1;
    end
  end

  // Next-state logic; a stop request only takes effect outside READ/DRAIN
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = enable ? ARM : IDLE;
      ARM:     w_next = !enable ? IDLE : (bus.dataAvailable ? READ : ARM);
      READ:    w_next = w_burst_done ? DRAIN : READ;
      DRAIN:   w_next = w_drain_done ? GAP : DRAIN;
      GAP:     w_next = w_gap_done ? (enable ? ARM : IDLE) : GAP;
      default: w_next = IDLE;
    endcase
  end

  // Output decode from the next state so the registered strobes align with it
  always_comb begin
    w_collect = (w_next != IDLE);
    w_busy    = (w_next != IDLE);
    w_read    = (w_next == READ);
    if (w_next == IDLE) begin
      w_test = 1'b0;
    end else if (r_state == IDLE) begin
      w_test = testModeReq;
    end else begin
      w_test = r_test;
    end
  end

  // Registered bus strobes and the readData -> sampleValid delay line
  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      r_collect <= 1'b0;
      r_test    <= 1'b0;
      r_read    <= 1'b0;
      r_busy    <= 1'b0;
      r_vpipe   <= '0;
    end else begin
      r_collect  <= w_collect;
      r_test     <= w_test;
      r_read     <= w_read;
      r_busy     <= w_busy;
      r_vpipe[0] <= r_read;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
      end
    end
  end

  fx3_pattern_checker #(
    .SAMPLE_BITS (SAMPLE_BITS)
  ) u_checker (
    .i_clk          (inclk),
    .i_rst          (reset),
    .i_sample_valid (w_sample_valid),
    .i_data         (bus.dataIn),
    .i_test_mode    (r_test),
    .i_seed_clear   (w_seed_clear),
    .o_mismatch     (w_mismatch),
    .o_expected     (w_expected_unused)
  );

  // Statistics, cleared when a new run is armed from IDLE
  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      r_word_cnt  <= 32'd0;
      r_burst_cnt <= 16'd0;
      r_err_cnt   <= 16'd0;
      r_err_seen  <= 1'b0;
    end else if (w_seed_clear) begin
      r_word_cnt  <= 32'd0;
      r_burst_cnt <= 16'd0;
      r_err_cnt   <= 16'd0;
      r_err_seen  <= 1'b0;
    end else begin
      if (w_sample_valid) begin
        r_word_cnt <= r_word_cnt + 32'd1;
      end
      if (w_drain_done) begin
        r_burst_cnt <= r_burst_cnt + 16'd1;
      end
      if (w_mismatch) begin
        r_err_seen <= 1'b1;
        if (r_err_cnt != 16'hFFFF) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
      end
    end
  end

  assign bus.collectData = r_collect;
  assign bus.testMode    = r_test;
  assign bus.readData    = r_read;
  assign busy            = r_busy;
  assign wordCount       = r_word_cnt;
  assign burstCount      = r_burst_cnt;
  assign errorCount      = r_err_cnt;
  assign errorSeen       = r_err_seen;

endmodule

// File: tb/tb_fx3_bus_reader.sv
// Directed/randomised bench for fx3_bus_reader: a generator model feeds words
// READ_LATENCY cycles after each consume, and a reference model tracks the stats.
module tb_fx3_bus_reader;
  import fx3_pkg::*;

  localparam int BL = 16;
  localparam int RL = 2;
  localparam int GC = 4;
  localparam int SB = 10;
  localparam int MOD = 1 << SB;

  logic        inclk = 1'b0;
  logic        reset, enable, testModeReq, busy, errorSeen;
  logic [31:0] wordCount;
  logic [15:0] burstCount, errorCount;

  fx3_bus_reader_if bus ();

  fx3_bus_reader #(
    .BURST_LEN(BL), .READ_LATENCY(RL), .GAP_CYCLES(GC), .SAMPLE_BITS(SB)
  ) dut (
    .inclk(inclk), .reset(reset), .enable(enable), .testModeReq(testModeReq),
    .bus(bus), .busy(busy), .wordCount(wordCount), .burstCount(burstCount),
    .errorCount(errorCount), .errorSeen(errorSeen)
  );

  always #5 inclk = ~inclk;

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [15:0] due[int];
  logic        pend_v = 1'b0;
  logic [15:0] pend_w;
  int  m_words, m_errs, m_exp;
  bit  m_seen, m_seeded, m_tm;
  int  gen_cnt, cons, corrupt_at;
  bit  rand_data, gap_chk;
  int  run_len, low_len, runs_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    m_words = 0; m_errs = 0; m_seen = 1'b0; m_seeded = 1'b0; m_exp = 0;
  endtask

  // Reference model of the counter-pattern rules, applied per received word
  task automatic model_word(input logic [15:0] w);
    int wi;
    wi = int'(w);
    m_words++;
    if (m_tm) begin
      if (!m_seeded) begin
        m_seeded = 1'b1;
        m_exp = (wi % MOD + 1) % MOD;
      end else if ((wi / MOD) != 0 || (wi % MOD) != m_exp) begin
        if (m_errs < 65535) m_errs++;
        m_seen = 1'b1;
        m_exp = (wi % MOD + 1) % MOD;
      end else begin
        m_exp = (m_exp + 1) % MOD;
      end
    end
  endtask

  function automatic logic [15:0] next_word();
    logic [15:0] w;
    if (cons == corrupt_at) w = 16'h0FFF;
    else if (rand_data) w = 16'($urandom);
    else w = 16'(gen_cnt % MOD);
    gen_cnt++;
    cons++;
    return w;
  endfunction

  // One clock: deliver due words, note consumes, track burst/gap lengths
  task automatic cycle();
    @(negedge inclk);
    cyc++;
    if (pend_v) model_word(pend_w);
    pend_v = 1'b0;
    if (due.exists(cyc)) begin
      bus.dataIn = due[cyc];
      pend_w = due[cyc];
      pend_v = 1'b1;
      due.delete(cyc);
    end else begin
      bus.dataIn = 16'($urandom);
    end
    if (bus.readData === 1'b1) begin
      if (run_len == 0 && gap_chk && runs_seen > 0) check("burst_gap", low_len, RL + GC + 1);
      due[cyc + RL] = next_word();
      run_len++;
    end else begin
      if (run_len > 0) begin
        check("burst_len", run_len, BL);
        runs_seen++;
        low_len = 0;
      end
      run_len = 0;
      low_len++;
    end
  endtask

  task automatic start_run(input bit tm, input int base, input int corrupt, input bit rnd);
    gen_cnt = base; corrupt_at = corrupt; rand_data = rnd; cons = 0;
    runs_seen = 0; low_len = 0;
    testModeReq = tm; m_tm = tm;
    m_clear();
    enable = 1'b1;
  endtask

  task automatic wait_run(input int k);
    for (int i = 0; i < 300 && run_len != k; i++) cycle();
    check("wait_read_cycle", run_len, k);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy !== 1'b0; i++) cycle();
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_stats(input int words, input int bursts, input int errs);
    check("wordCount_model", wordCount, m_words);
    check("wordCount", wordCount, words);
    check("burstCount", 32'(burstCount), bursts);
    check("errorCount_model", 32'(errorCount), m_errs);
    check("errorCount", 32'(errorCount), errs);
    check("errorSeen", 32'(errorSeen), 32'(errs != 0));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; testModeReq = 1'b0;
    bus.dataAvailable = 1'b0; bus.dataIn = 16'd0;
    gap_chk = 1'b0; run_len = 0; low_len = 0; runs_seen = 0;
    corrupt_at = -1; cons = 0; gen_cnt = 0; rand_data = 1'b0; m_tm = 1'b0;
    m_clear();
    repeat (3) cycle();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_readData", 32'(bus.readData), 32'd0);
    check("rst_collectData", 32'(bus.collectData), 32'd0);
    check("rst_testMode", 32'(bus.testMode), 32'd0);
    check_stats(0, 0, 0);
    reset = 1'b0;
    repeat (2) cycle();
    check("idle_busy", 32'(busy), 32'd0);

    // Three back-to-back bursts of a clean counter in test mode
    bus.dataAvailable = 1'b1;
    gap_chk = 1'b1;
    start_run(1'b1, 0, -1, 1'b0);
    for (int i = 0; i < 600 && cons < 3 * BL; i++) cycle();
    check("three_burst_consumes", cons, 3 * BL);
    enable = 1'b0;
    wait_idle();
    check_stats(3 * BL, 3, 0);
    gap_chk = 1'b0;

    // Counter wraps 1023 -> 0 inside one burst
    start_run(1'b1, MOD - 8, -1, 1'b0);
    wait_run(1);
    enable = 1'b0;
    wait_idle();
    check_stats(BL, 1, 0);

    // Word 5 corrupted with upper bits set: the bad word and its successor count
    start_run(1'b1, int'($urandom_range(0, 1000)), 5, 1'b0);
    wait_run(1);
    enable = 1'b0;
    wait_idle();
    check_stats(BL, 1, 2);

    // No data available: stays armed, readData follows dataAvailable one cycle later
    bus.dataAvailable = 1'b0;
    start_run(1'b0, 0, -1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("arm_collectData", 32'(bus.collectData), 32'd1);
      check("arm_readData", 32'(bus.readData), 32'd0);
    end
    check("arm_testMode", 32'(bus.testMode), 32'd0);
    bus.dataAvailable = 1'b1;
    cycle();
    check("avail_readData_rise", 32'(bus.readData), 32'd1);
    enable = 1'b0;
    wait_idle();
    check_stats(BL, 1, 0);

    // Stop requested at READ cycle 3: burst finishes, then DRAIN + GAP
    start_run(1'b1, int'($urandom_range(0, 1023)), -1, 1'b0);
    wait_run(3);
    enable = 1'b0;
    for (int i = 0; i < 100 && bus.readData === 1'b1; i++) cycle();
    begin
      int n;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
        n++;
        cycle();
      end
      check("drain_gap_cycles", n, RL + GC);
    end
    check("stop_busy", 32'(busy), 32'd0);
    check_stats(BL, 1, 0);

    // Reset at READ cycle 7 aborts at once; the next run reseeds cleanly
    start_run(1'b1, 0, -1, 1'b0);
    wait_run(7);
    reset = 1'b1;
    #1;
    check("abort_readData", 32'(bus.readData), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wordCount", wordCount, 32'd0);
    due.delete();
    pend_v = 1'b0;
    run_len = 0;
    m_clear();
    repeat (2) cycle();
    reset = 1'b0;
    gen_cnt = 600;
    cons = 0;
    wait_run(1);
    enable = 1'b0;
    wait_idle();
    check_stats(BL, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fx3_bus_reader.md
Name: fx3_bus_reader

Overview:
- Synthesizable read-side model of the FX3 GPIF interface, for loopback and bring-up builds.
- Drives collectData, testMode and readData toward the data generator and watches dataAvailable.
- Pulls fixed-length bursts off the 16-bit databus and checks the test-mode counter pattern.
- Reports word, burst and error counts.

Parameters:
- BURST_LEN, 8192: words read per burst (readData-high cycles per burst).
- READ_LATENCY, 2: cycles from a readData-high edge to the matching valid word on dataIn (min 1).
- GAP_CYCLES, 4: idle cycles between bursts (min 1).
- SAMPLE_BITS, 10: width of the test counter in the low bits of each word.

Ports:
- inclk  input  1  system clock (64 MHz GPIF clock)
- reset  input  1  asynchronous, active-high reset
- enable  input  1  level; 1 = run capture, 0 = stop after the current burst
- testModeReq  input  1  value driven onto testMode while running
- dataAvailable  input  1  generator has at least BURST_LEN words buffered
- dataIn  input  16  generator databus
- collectData  output  1  to generator
- testMode  output  1  to generator
- readData  output  1  to generator; 1 = word consumed this cycle
- busy  output  1  state is not IDLE
- wordCount  output  32  valid words received, wraps modulo 2^32
- burstCount  output  16  completed bursts, wraps
- errorCount  output  16  pattern mismatches, saturates at 0xFFFF
- errorSeen  output  1  sticky; set on the first mismatch

Behaviour:
- Reset (async, active-high): all outputs are 0; state is IDLE; the valid pipe and expected counter are cleared. Reset asserted mid-burst aborts immediately, and readData drops in the same cycle.
- State machine, all registered:
  - IDLE: enable=1 → ARM, and statistics and errorSeen are cleared in the same edge.
  - ARM: collectData=1, testMode=testModeReq (latched on IDLE→ARM). dataAvailable=1 → READ next cycle. enable=0 → IDLE.
  - READ: readData=1 for exactly BURST_LEN consecutive cycles (burst counter 0..BURST_LEN-1), then → DRAIN. enable and dataAvailable are ignored until the burst completes.
  - DRAIN: readData=0; hold for READ_LATENCY cycles so in-flight words land, then → GAP, and burstCount increments on that edge.
  - GAP: hold GAP_CYCLES cycles. Then enable=1 → ARM, enable=0 → IDLE (collectData=0 from IDLE).
- Valid pipe: a READ_LATENCY-deep shift register of readData. Its output sampleValid qualifies dataIn. It runs independently of state, so exactly BURST_LEN valid words arrive per burst.
- Per valid word: wordCount +1.
- Pattern check, only when testMode=1:
  - The first valid word after IDLE→ARM seeds expected = dataIn[SAMPLE_BITS-1:0] + 1, and is not checked.
  - Each later valid word: mismatch if dataIn[15:SAMPLE_BITS] != 0 or dataIn[SAMPLE_BITS-1:0] != expected.
  - On a mismatch: errorCount +1 (saturating), errorSeen=1, resync expected = dataIn[SAMPLE_BITS-1:0] + 1. A single corrupt word therefore costs at most 2 errors (the bad word and its successor), and a dropped word costs 1.
  - On a match: expected +1.
- Arithmetic: expected wraps modulo 2^SAMPLE_BITS (1023 → 0 is not an error).
- Seeding persists across bursts, so continuity is checked across burst boundaries.
- testMode=0: data is counted but not checked.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package (fx3_pkg):
  - state encoding constants IDLE/ARM/READ/DRAIN/GAP;
  - DATA_WIDTH=16 and SAMPLE_BITS default.
- One natural sub-module: fx3_pattern_checker, which takes sampleValid, dataIn, testMode and seed-clear, and returns the mismatch pulse and expected value.
- Counters and the FSM stay in the top level.

Test Plan:
- Generator emitting 0,1,2,… in test mode; BURST_LEN=16, READ_LATENCY=2, enable held for 3 bursts → readData high 16 cycles per burst, wordCount=48, burstCount=3, errorCount=0, errorSeen=0.
- Counter crossing 1020..1023,0,1 within one burst → no error; expected wraps to 0.
- Word 5 of a burst replaced by 0x0FFF (upper bits nonzero) → errorCount=2, errorSeen=1; later words clean.
- dataAvailable held 0 → stays in ARM with collectData=1 and readData never asserts. Raising it → readData rises exactly 1 cycle later.
- enable dropped at READ cycle 3 → burst completes (16 readData cycles), DRAIN and GAP run, then IDLE. burstCount +1, busy=0.
- reset pulsed at READ cycle 7 → readData, counters and busy are 0 immediately. After release with enable=1, a fresh burst starts and the first word reseeds without an error.
